// File: rtl/wb_host_pkg.sv
// -----------------------------------------------------------------------------
// wb_host_pkg
// Shared definitions for the Wishbone host master: FSM state encoding and the
// response status codes returned on rsp_status_o.
// -----------------------------------------------------------------------------
package wb_host_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] WBH_OK      = 2'b00;
  localparam logic [1:0] WBH_ERR     = 2'b01;
  localparam logic [1:0] WBH_TIMEOUT = 2'b10;

endpackage

// File: rtl/wb_host_watchdog.sv
// -----------------------------------------------------------------------------
// wb_host_watchdog
// Cycle counter that flags a bus cycle the slave never answers.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the count (pulsed when a new bus cycle starts)
//   enable     : count this cycle (high while the master is in REQ)
//   expired    : high in the enabled cycle whose closing edge brings the count
//                to TIMEOUT, so the bus cycle lasts exactly TIMEOUT cycles
// -----------------------------------------------------------------------------
module wb_host_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process ordering in simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 1'b1;
  end

  // The count shows completed REQ cycles, so the current cycle is the last
  // allowed one when count == TIMEOUT-1.
  assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_host_master.sv
// -----------------------------------------------------------------------------
// wb_host_master
// Wishbone classic (B3) single-access initiator. Takes one command at a time on
// a valid/ready interface, runs one read or write cycle on the master port and
// returns data plus status on a valid/ready response interface.
//
// Ports
//   wb_clk_i, wb_rst_ni         clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o     command handshake
//   cmd_we_i/adr_i/dat_i/sel_i  command fields
//   rsp_valid_o/rsp_ready_i     response handshake
//   rsp_dat_o, rsp_status_o     read data (0 unless OK read), status code
//   wbm_*                       Wishbone master port
//   busy_o                      high while a command is in flight
//
// Build option: define WB_HOST_TIMEOUT_EN to compile in the watchdog that ends
// a cycle after TIMEOUT REQ cycles with status WBH_TIMEOUT. Without it, REQ
// waits for ack or err indefinitely and TIMEOUT has no effect.
// -----------------------------------------------------------------------------
module wb_host_master
  import wb_host_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic [1:0]  rsp_status_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic        busy_o
);

  state_t      state, state_nxt;
  logic        cmd_fire;
  logic        wd_expired;
  logic        rsp_load;
  logic [1:0]  rsp_status_nxt;
  logic [31:0] rsp_dat_nxt;

  // Gated by reset so ready reads 0 while reset is held, even though the
  // state register already sits in IDLE.
  assign cmd_ready_o = (state == IDLE) && wb_rst_ni;
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;

  // Bus strobes decode straight from the state register, so the asynchronous
  // reset of that register drops them immediately.
  assign wbm_cyc_o   = (state == REQ);
  assign wbm_stb_o   = (state == REQ);
  assign rsp_valid_o = (state == RESP);
  assign busy_o      = (state != IDLE);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= IDLE;
    else            state <= state_nxt;
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt      = state;
    rsp_load       = 1'b0;
    rsp_status_nxt = WBH_OK;
    rsp_dat_nxt    = '0;
    case (state)
      IDLE: if (cmd_fire) state_nxt = REQ;
      REQ: begin
        // Priority: err over ack over watchdog on the same edge.
        if (wbm_err_i) begin
          state_nxt      = RESP;
          rsp_load       = 1'b1;
          rsp_status_nxt = WBH_ERR;
        end else if (wbm_ack_i) begin
          state_nxt   = RESP;
          rsp_load    = 1'b1;
          rsp_dat_nxt = wbm_we_o ? '0 : wbm_dat_i;
        end else if (wd_expired) begin
          state_nxt      = RESP;
          rsp_load       = 1'b1;
          rsp_status_nxt = WBH_TIMEOUT;
        end
      end
      RESP:    if (rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus fields change only on a command handshake and hold afterwards.
  // NOTE: these are plain flops, not a memory array, so they take the
  // asynchronous reset like the rest of the state.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
    end else if (cmd_fire) begin
      wbm_we_o  <= cmd_we_i;
      wbm_sel_o <= cmd_sel_i;
      wbm_adr_o <= cmd_adr_i;
      wbm_dat_o <= cmd_we_i ? cmd_dat_i : '0;
    end
  end

  // Response is captured once on REQ exit and held through RESP.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      rsp_dat_o    <= '0;
      rsp_status_o <= WBH_OK;
    end else if (rsp_load) begin
      rsp_dat_o    <= rsp_dat_nxt;
      rsp_status_o <= rsp_status_nxt;
    end
  end

`ifdef WB_HOST_TIMEOUT_EN
  wb_host_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .clear   (cmd_fire),
    .enable  (state == REQ),
    .expired (wd_expired)
  );
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign wd_expired     = 1'b0;
`endif

endmodule

// File: tb/tb_wb_host_master.sv
// -----------------------------------------------------------------------------
// tb_wb_host_master
// Self-checking bench: a table of directed vectors with hand-written expected
// results, randomized transactions scored against a transaction-level model,
// and hand-written sequences for reset-mid-cycle and a silent slave.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_wb_host_master;

  localparam int unsigned TMO = 16;
`ifdef WB_HOST_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef enum int {K_ACK, K_ERR, K_BOTH, K_NONE} kind_t;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          waits;       // wait states before the slave answers
    kind_t       kind;
    logic [31:0] rdat;
    int          stall;       // cycles rsp_ready_i is held low
    bit          noise;       // random ack/err while not in REQ
    logic [1:0]  exp_status;
    logic [31:0] exp_dat;
    int          exp_cycles;  // cycles wbm_cyc_o is high
  } vec_t;

  logic        wb_clk_i, wb_rst_ni;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_adr_i, cmd_dat_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_dat_o;
  logic [1:0]  rsp_status_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        wbm_ack_i, wbm_err_i, busy_o;

  int n_cmp = 0;
  int n_err = 0;

  wb_host_master #(.TIMEOUT(TMO)) dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_ni    (wb_rst_ni),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_we_i     (cmd_we_i),
    .cmd_adr_i    (cmd_adr_i),
    .cmd_dat_i    (cmd_dat_i),
    .cmd_sel_i    (cmd_sel_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_dat_o    (rsp_dat_o),
    .rsp_status_o (rsp_status_o),
    .wbm_cyc_o    (wbm_cyc_o),
    .wbm_stb_o    (wbm_stb_o),
    .wbm_we_o     (wbm_we_o),
    .wbm_sel_o    (wbm_sel_o),
    .wbm_adr_o    (wbm_adr_o),
    .wbm_dat_o    (wbm_dat_o),
    .wbm_dat_i    (wbm_dat_i),
    .wbm_ack_i    (wbm_ack_i),
    .wbm_err_i    (wbm_err_i),
    .busy_o       (busy_o)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: when does the slave answer, and does the
  // watchdog get there first? Same-edge ties go to the slave.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int   answer_at = (v.kind == K_NONE) ? 32'h4000_0000 : v.waits + 1;
    if (TMO_EN && TMO < answer_at) begin
      r.exp_status = 2'b10; r.exp_dat = 0; r.exp_cycles = TMO;
    end else begin
      r.exp_cycles = answer_at;
      if (v.kind == K_ACK) begin
        r.exp_status = 2'b00; r.exp_dat = v.we ? 32'h0 : v.rdat;
      end else begin
        r.exp_status = 2'b01; r.exp_dat = 0;
      end
    end
    return r;
  endfunction

  task automatic slave_noise(input bit noise);
    wbm_ack_i = noise ? 1'($urandom) : 1'b0;
    wbm_err_i = noise ? 1'($urandom) : 1'b0;
    wbm_dat_i = $urandom;
  endtask

  // Runs one transaction; called on a falling edge, returns on a falling edge
  // with the FSM back in IDLE.
  task automatic run_txn(input vec_t v);
    int         n = 0;
    int         guard = 0;
    bit         got = 0;
    logic [1:0] st;
    logic [31:0] d;
    cmd_valid_i = 1'b1; cmd_we_i = v.we; cmd_adr_i = v.adr;
    cmd_dat_i = v.dat;  cmd_sel_i = v.sel;
    while (!cmd_ready_o && guard < 50) begin @(negedge wb_clk_i); guard++; end
    if (!cmd_ready_o) begin check("cmd_accept_bound", 0, 1); cmd_valid_i = 0; return; end
    @(negedge wb_clk_i);
    // Scramble the command inputs: the bus must keep the registered values.
    cmd_valid_i = 1'b0; cmd_we_i = $urandom; cmd_adr_i = $urandom;
    cmd_dat_i = $urandom; cmd_sel_i = $urandom;
    for (int c = 0; c < 3000 && !got; c++) begin
      if (rsp_valid_o) got = 1;
      else begin
        if (wbm_cyc_o) begin
          n++;
          check("bus_stb", wbm_stb_o, 1);
          check("bus_adr", wbm_adr_o, v.adr);
          check("bus_we",  wbm_we_o, v.we);
          check("bus_sel", wbm_sel_o, v.sel);
          check("bus_dat", wbm_dat_o, v.we ? v.dat : 32'h0);
          if (v.kind != K_NONE && n == v.waits + 1) begin
            wbm_ack_i = (v.kind != K_ERR);
            wbm_err_i = (v.kind != K_ACK);
            wbm_dat_i = v.rdat;
          end else begin
            wbm_ack_i = 0; wbm_err_i = 0; wbm_dat_i = $urandom;
          end
        end else slave_noise(v.noise);
        @(negedge wb_clk_i);
      end
    end
    if (!got) begin check("rsp_bound", 0, 1); wbm_ack_i = 0; wbm_err_i = 0; return; end
    check("cyc_cycles", n, v.exp_cycles);
    check("rsp_status", rsp_status_o, v.exp_status);
    check("rsp_dat",    rsp_dat_o, v.exp_dat);
    check("cyc_in_resp", wbm_cyc_o, 0);
    check("busy_in_resp", busy_o, 1);
    st = rsp_status_o; d = rsp_dat_o;
    for (int s = 0; s < v.stall; s++) begin
      slave_noise(v.noise);
      // A command offered during the stall must not be taken.
      cmd_valid_i = 1'b1; cmd_adr_i = $urandom;
      @(negedge wb_clk_i);
      check("stall_valid",  rsp_valid_o, 1);
      check("stall_status", rsp_status_o, st);
      check("stall_dat",    rsp_dat_o, d);
      check("stall_ready",  cmd_ready_o, 0);
      check("stall_cyc",    wbm_cyc_o, 0);
    end
    cmd_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge wb_clk_i);
    rsp_ready_i = 1'b0; wbm_ack_i = 0; wbm_err_i = 0;
    check("idle_valid", rsp_valid_o, 0);
    check("idle_ready", cmd_ready_o, 1);
    check("hold_adr",   wbm_adr_o, v.adr);
    check("hold_dat",   wbm_dat_o, v.we ? v.dat : 32'h0);
  endtask

  // Starts a read the slave ignores, holds it for 'hold' cycles, then resets
  // mid-REQ and confirms a clean recovery.
  task automatic reset_mid_req(input int hold);
    int   held = 0;
    vec_t r;
    cmd_valid_i = 1; cmd_we_i = 0; cmd_adr_i = 32'h3000_0100; cmd_sel_i = 4'hF;
    @(negedge wb_clk_i);
    cmd_valid_i = 0;
    wbm_ack_i = 0; wbm_err_i = 0;
    for (int c = 0; c < hold; c++) begin
      if (wbm_cyc_o && !rsp_valid_o) held++;
      @(negedge wb_clk_i);
    end
    check("silent_cyc_held", held, hold);
    #2 wb_rst_ni = 1'b0;
    #1;
    check("rst_cyc",    wbm_cyc_o, 0);
    check("rst_stb",    wbm_stb_o, 0);
    check("rst_busy",   busy_o, 0);
    check("rst_ready",  cmd_ready_o, 0);
    check("rst_adr",    wbm_adr_o, 0);
    check("rst_sel",    wbm_sel_o, 0);
    check("rst_valid",  rsp_valid_o, 0);
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    @(negedge wb_clk_i);
    check("post_rst_valid", rsp_valid_o, 0);
    check("post_rst_ready", cmd_ready_o, 1);
    r = '{we:0, adr:32'h3000_0200, dat:0, sel:4'hF, waits:1, kind:K_ACK,
          rdat:32'hCAFE_F00D, stall:0, noise:0,
          exp_status:2'b00, exp_dat:32'hCAFE_F00D, exp_cycles:2};
    run_txn(r);
  endtask

  vec_t vecs[$];

  initial begin
    wb_rst_ni = 0; cmd_valid_i = 0; cmd_we_i = 0; cmd_adr_i = 0; cmd_dat_i = 0;
    cmd_sel_i = 0; rsp_ready_i = 0; wbm_dat_i = 0; wbm_ack_i = 0; wbm_err_i = 0;

    vecs.push_back('{0, 32'h3000_0000, 0,            4'hF, 0, K_ACK,  32'hDEAD_BEEF, 0, 0, 2'b00, 32'hDEAD_BEEF, 1});
    vecs.push_back('{1, 32'h3000_0004, 32'h1234_5678, 4'hF, 3, K_ACK,  32'h5555_AAAA, 0, 0, 2'b00, 32'h0, 4});
    vecs.push_back('{0, 32'h3000_0008, 0,            4'hF, 2, K_BOTH, 32'hAAAA_5555, 0, 0, 2'b01, 32'h0, 3});
    vecs.push_back('{1, 32'h3000_000C, 32'h0BAD_0BAD, 4'h3, 1, K_ERR,  32'h1111_2222, 0, 1, 2'b01, 32'h0, 2});
    vecs.push_back('{0, 32'h3000_0010, 0,            4'h1, 5, K_ACK,  32'h0000_00A5, 2, 1, 2'b00, 32'h0000_00A5, 6});
    vecs.push_back('{1, 32'h3000_0014, 32'hFFFF_0000, 4'hC, 0, K_ACK,  32'h9999_9999, 5, 0, 2'b00, 32'h0, 1});
    // Ack in the last allowed cycle beats the watchdog on the same edge.
    vecs.push_back('{0, 32'h3000_0018, 0,            4'hF, 15, K_ACK, 32'h0F0F_F0F0, 0, 0, 2'b00, 32'h0F0F_F0F0, 16});
`ifdef WB_HOST_TIMEOUT_EN
    vecs.push_back('{0, 32'h3000_001C, 0,            4'hF, 16, K_ACK, 32'h7777_7777, 0, 0, 2'b10, 32'h0, 16});
    vecs.push_back('{1, 32'h3000_0020, 32'h2222_3333, 4'hF, 0, K_NONE, 32'h0, 1, 1, 2'b10, 32'h0, 16});
`else
    vecs.push_back('{0, 32'h3000_001C, 0,            4'hF, 16, K_ACK, 32'h7777_7777, 0, 0, 2'b00, 32'h7777_7777, 17});
`endif

    // Reset values while reset is held.
    repeat (3) @(negedge wb_clk_i);
    check("reset_ready",  cmd_ready_o, 0);
    check("reset_cyc",    wbm_cyc_o, 0);
    check("reset_valid",  rsp_valid_o, 0);
    check("reset_busy",   busy_o, 0);
    check("reset_adr",    wbm_adr_o, 0);
    check("reset_dat",    wbm_dat_o, 0);
    check("reset_rspdat", rsp_dat_o, 0);
    check("reset_status", rsp_status_o, 0);
    wb_rst_ni = 1;
    @(negedge wb_clk_i);
    check("first_idle_ready", cmd_ready_o, 1);

    foreach (vecs[i]) run_txn(vecs[i]);

    for (int i = 0; i < 40; i++) begin
      vec_t v;
      v.we = $urandom; v.adr = $urandom; v.dat = $urandom; v.sel = $urandom;
      v.waits = $urandom_range(0, 20);
      v.kind  = kind_t'($urandom_range(0, TMO_EN ? 3 : 2));
      v.rdat  = $urandom; v.stall = $urandom_range(0, 3); v.noise = $urandom;
      run_txn(model(v));
    end

`ifdef WB_HOST_TIMEOUT_EN
    reset_mid_req(5);
`else
    reset_mid_req(1000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_host_master.md
# wb_host_master

Wishbone classic (B3, single-access) initiator for the user project area: the bus-master counterpart to the slave port the wrapper exposes to the management SoC. It accepts one command at a time on a valid/ready interface, runs a single read or write cycle on its own Wishbone master port, and returns data plus status on a valid/ready response interface. An optional watchdog ends cycles the addressed slave never answers.

## Interface
- TIMEOUT, 255: cycles spent in REQ, counting the first REQ cycle, before a watchdog abort. Legal range 1..65535.
- wb_clk_i  in  1  single clock; all logic is rising-edge.
- wb_rst_ni  in  1  reset; asynchronous assert, active-low.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted this cycle when high together with cmd_valid_i.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  32  byte address.
- cmd_dat_i  in  32  write data.
- cmd_sel_i  in  4  byte selects.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed this cycle when high together with rsp_valid_o.
- rsp_dat_o  out  32  read data. Value is 0 for writes, errors and timeouts.
- rsp_status_o  out  2  00 OK, 01 bus error, 10 timeout. 11 is never driven.
- wbm_cyc_o, wbm_stb_o  out  1  bus cycle and strobe; always equal.
- wbm_we_o  out  1  write enable.
- wbm_sel_o  out  4  byte selects.
- wbm_adr_o  out  32  address.
- wbm_dat_o  out  32  write data.
- wbm_dat_i  in  32  read data from the slave.
- wbm_ack_i  in  1  slave acknowledge.
- wbm_err_i  in  1  slave error.
- busy_o  out  1  high in REQ or RESP.

## Operation
- The FSM has three states: IDLE, REQ and RESP. Reset enters IDLE.
- cmd_ready_o = (state == IDLE).
- IDLE -> REQ on a command handshake:
  - cmd_we_i, cmd_sel_i and cmd_adr_i are registered onto wbm_we_o, wbm_sel_o and wbm_adr_o.
  - wbm_dat_o takes cmd_dat_i for writes and 0 for reads.
- REQ:
  - wbm_cyc_o and wbm_stb_o are 1. All wbm_* outputs are stable.
  - err sampled: go to RESP with status 01 and data 0.
  - ack sampled: go to RESP with status 00. Data is wbm_dat_i for reads and 0 for writes.
  - Watchdog limit reached: go to RESP with status 10 and data 0.
- RESP:
  - wbm_cyc_o and wbm_stb_o are 0. rsp_valid_o is 1.
  - rsp_dat_o and rsp_status_o are stable until the handshake.
  - On the handshake, go to IDLE.
- Precedence inside REQ on the same edge: err > ack > timeout.
- wbm_adr_o, wbm_sel_o, wbm_we_o and wbm_dat_o hold their last values after a cycle ends. They change only on a command handshake.
- ack or err sampled outside REQ is ignored.
- Reset mid-operation: wbm_cyc_o and wbm_stb_o drop immediately (asynchronous). Any response is discarded and is not replayed.
- Reset values: cmd_ready_o 0 while reset is asserted, then 1 from the first cycle in IDLE. Every other output is 0.

## Timing
- Command handshake at edge E0: wbm_cyc_o and wbm_stb_o are high in the cycle after E0.
- A slave that acks combinationally in that first cycle gives ack sampled at E1. rsp_valid_o is high in the cycle after E1.
- With rsp_ready_i held high, the FSM returns to IDLE after E2. The next command can be accepted at E3.
- Best-case throughput: 1 transaction per 3 cycles.
- Each wait state the slave inserts adds 1 cycle.
- The watchdog counter clears on entry to REQ and increments every REQ cycle.
- Timeout fires on the edge where the count reaches TIMEOUT: wbm_cyc_o is high for exactly TIMEOUT cycles.

## Configuration
- WB_HOST_TIMEOUT_EN defined:
  - The watchdog is compiled in and behaves as described above.
  - Status 10 is reachable.
- WB_HOST_TIMEOUT_EN undefined:
  - No watchdog logic. REQ waits for ack or err indefinitely.
  - Status 10 is never produced. TIMEOUT is ignored.

## Structure
- Shared package wb_host_pkg holds:
  - the state enum (IDLE, REQ, RESP);
  - the status constants WBH_OK = 2'b00, WBH_ERR = 2'b01 and WBH_TIMEOUT = 2'b10.
- One sub-module, wb_host_watchdog:
  - Ports: clear, enable, expired.
  - Counter width is $clog2(TIMEOUT+1).
  - Instantiated only under WB_HOST_TIMEOUT_EN.

## Test plan
- Read with a slave that acks on the first REQ cycle and returns 0xDEADBEEF: rsp_valid_o is high 2 cycles after the handshake, with status 00 and data 0xDEADBEEF. wbm_cyc_o is high for exactly 1 cycle.
- Write to adr 0x3000_0004, dat 0x1234_5678, sel 0xF, with 3 wait states: wbm_* outputs are held for 4 cycles and the bus signals match the command. The response has status 00 and data 0.
- Slave asserts ack and err together: status is 01, data is 0.
- Slave never responds, TIMEOUT = 16, macro defined: wbm_cyc_o is high for 16 cycles and the response has status 10. With the macro undefined, wbm_cyc_o stays high for at least 1000 cycles and no response appears.
- rsp_ready_i held low for 5 cycles: the response is stable throughout, cmd_ready_o stays 0, and a pending cmd_valid_i is not accepted until after the response handshake.
- wb_rst_ni asserted in the middle of REQ: wbm_cyc_o goes low in the same cycle and all outputs return to 0. After release, a new read completes normally.
